// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline buffer: state encoding,
// occupancy width and default bundle widths per stage boundary.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int OCC_W = 2;

  localparam int FD_CTRL_W = 8;
  localparam int FD_DATA_W = 64;
  localparam int DE_CTRL_W = 8;
  localparam int DE_DATA_W = 160;
  localparam int EM_CTRL_W = 8;
  localparam int EM_DATA_W = 160;
  localparam int MW_CTRL_W = 8;
  localparam int MW_DATA_W = 96;

  function automatic logic [OCC_W-1:0] occ_of(input logic [1:0] st);
    case (st)
      ST_FULL: return 2'd2;
      ST_ONE:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One buffer slot: valid bit plus control and data registers.
// Clear wins over load; data survives a clear unless CLR_DATA is set.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = EM_CTRL_W,
  parameter int DATA_W   = EM_DATA_W,
  parameter int CLR_DATA = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              load,
  input  logic              unload,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      ctrl  <= '0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      ctrl  <= '0;
      if (CLR_DATA != 0) data <= '0;
    end else if (load) begin
      valid <= 1'b1;
      ctrl  <= in_ctrl;
      data  <= in_data;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline buffer with valid/ready handshake, optional skid slot,
// flush-to-bubble and a saturating stall-cycle counter.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int CTRL_W   = EM_CTRL_W,
  parameter int DATA_W   = EM_DATA_W,
  parameter int SKID     = 1,
  parameter int CLR_DATA = 0,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [OCC_W-1:0]  occupancy,
  output logic [PERF_W-1:0] stall_cnt
);

  logic              m_valid, s_valid;
  logic [CTRL_W-1:0] m_ctrl, m_in_ctrl;
  logic [DATA_W-1:0] m_data, m_in_data;
  logic              m_load, m_unload;
  logic [1:0]        st;
  logic              in_fire, out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid & out_ready;
  assign st       = s_valid ? ST_FULL : (m_valid ? ST_ONE : ST_EMPTY);

  pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) m_slot (
    .clk     (clk),
    .reset   (reset),
    .clear   (flush),
    .load    (m_load),
    .unload  (m_unload),
    .in_ctrl (m_in_ctrl),
    .in_data (m_in_data),
    .valid   (m_valid),
    .ctrl    (m_ctrl),
    .data    (m_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic              s_load, s_unload, m_sel_s, in_ready_reg;
      logic [CTRL_W-1:0] s_ctrl;
      logic [DATA_W-1:0] s_data;

      pipe_slot #(.CTRL_W(CTRL_W), .DATA_W(DATA_W), .CLR_DATA(CLR_DATA)) s_slot (
        .clk     (clk),
        .reset   (reset),
        .clear   (flush),
        .load    (s_load),
        .unload  (s_unload),
        .in_ctrl (in_ctrl),
        .in_data (in_data),
        .valid   (s_valid),
        .ctrl    (s_ctrl),
        .data    (s_data)
      );

      always_comb begin
        m_load   = 1'b0;
        m_unload = 1'b0;
        m_sel_s  = 1'b0;
        s_load   = 1'b0;
        s_unload = 1'b0;
        case (st)
          ST_EMPTY: m_load = in_fire;
          ST_ONE: begin
            if (in_fire && out_fire) m_load = 1'b1;
            else if (in_fire)        s_load = 1'b1;
            else if (out_fire)       m_unload = 1'b1;
          end
          ST_FULL: begin
            if (out_fire) begin
              m_load   = 1'b1;
              m_sel_s  = 1'b1;
              s_unload = 1'b1;
            end
          end
          default: ;
        endcase
      end

      assign m_in_ctrl = m_sel_s ? s_ctrl : in_ctrl;
      assign m_in_data = m_sel_s ? s_data : in_data;

      // Registered copy of !s_valid so in_ready has no path from out_ready.
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          in_ready_reg <= 1'b1;
        end else if (st == ST_ONE && in_fire && !out_fire) begin
          in_ready_reg <= 1'b0;
        end else if (st == ST_FULL && out_fire) begin
          in_ready_reg <= 1'b1;
        end
      end

      assign in_ready = in_ready_reg;
    end else begin : g_noskid
      assign s_valid   = 1'b0;
      assign in_ready  = !m_valid | out_ready;
      assign m_load    = in_fire;
      assign m_unload  = out_fire & !in_fire;
      assign m_in_ctrl = in_ctrl;
      assign m_in_data = in_data;
    end
  endgenerate

  assign out_valid = m_valid;
  assign out_ctrl  = m_valid ? m_ctrl : '0;
  assign out_data  = m_data;
  assign occupancy = occ_of(st);

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (m_valid && !out_ready && (stall_cnt != {PERF_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Checks a skid (SKID=1) and a single-register (SKID=0) buffer against
// queue-based reference models under directed and random traffic.
module tb_pipe_stage_buf;

  localparam int CW = 8;
  localparam int DW = 160;
  localparam int PW = 4;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic reset;
  logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [CW-1:0] a_in_ctrl, a_out_ctrl;
  logic [DW-1:0] a_in_data, a_out_data;
  logic [1:0]    a_occ;
  logic [PW-1:0] a_stall;
  logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [CW-1:0] b_in_ctrl, b_out_ctrl;
  logic [DW-1:0] b_in_data, b_out_data;
  logic [1:0]    b_occ;
  logic [PW-1:0] b_stall;

  int total = 0;
  int bad = 0;

  ent_t qa[$];
  ent_t qb[$];
  logic [DW-1:0] ma, mb;
  int sa, sb;

  always #5 clk = ~clk;

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(1), .CLR_DATA(0), .PERF_W(PW)) dut (
    .clk(clk), .reset(reset), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .occupancy(a_occ), .stall_cnt(a_stall)
  );

  pipe_stage_buf #(.CTRL_W(CW), .DATA_W(DW), .SKID(0), .CLR_DATA(0), .PERF_W(PW)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .occupancy(b_occ), .stall_cnt(b_stall)
  );

  task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // Check outputs against the models, then advance models across one edge.
  task automatic tick();
    logic a_ir, a_ov, a_if, a_of, b_ir, b_ov, b_if, b_of;
    ent_t ea, eb;
    #1;
    a_ov = qa.size() > 0;
    a_ir = qa.size() < 2;
    b_ov = qb.size() > 0;
    b_ir = (qb.size() == 0) || b_out_ready;
    chk("a_in_ready", a_in_ready, a_ir);
    chk("a_out_valid", a_out_valid, a_ov);
    chk("a_out_ctrl", a_out_ctrl, a_ov ? qa[0].c : 8'h00);
    chk("a_out_data", a_out_data, ma);
    chk("a_occupancy", a_occ, qa.size());
    chk("a_stall_cnt", a_stall, sa);
    chk("b_in_ready", b_in_ready, b_ir);
    chk("b_out_valid", b_out_valid, b_ov);
    chk("b_out_ctrl", b_out_ctrl, b_ov ? qb[0].c : 8'h00);
    chk("b_out_data", b_out_data, mb);
    chk("b_occupancy", b_occ, qb.size());
    chk("b_stall_cnt", b_stall, sb);
    a_if = a_in_valid && a_ir;
    a_of = a_ov && a_out_ready;
    b_if = b_in_valid && b_ir;
    b_of = b_ov && b_out_ready;
    ea = '{c: a_in_ctrl, d: a_in_data};
    eb = '{c: b_in_ctrl, d: b_in_data};
    @(posedge clk);
    if (reset) begin
      qa.delete(); qb.delete();
      ma = '0; mb = '0; sa = 0; sb = 0;
    end else begin
      if (a_ov && !a_out_ready && sa < 15) sa++;
      if (b_ov && !b_out_ready && sb < 15) sb++;
      if (a_flush) qa.delete();
      else begin
        if (a_of) void'(qa.pop_front());
        if (a_if) qa.push_back(ea);
        if (qa.size() > 0) ma = qa[0].d;
      end
      if (b_flush) qb.delete();
      else begin
        if (b_of) void'(qb.pop_front());
        if (b_if) qb.push_back(eb);
        if (qb.size() > 0) mb = qb[0].d;
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c, input logic r, input logic f);
    a_in_valid = v; b_in_valid = v;
    a_in_ctrl = c;  b_in_ctrl = c;
    a_in_data = rnd_data(); b_in_data = a_in_data;
    a_out_ready = r; b_out_ready = r;
    a_flush = f; b_flush = f;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    a_flush = 0; a_in_valid = 0; a_in_ctrl = 0; a_in_data = 0; a_out_ready = 0;
    b_flush = 0; b_in_valid = 0; b_in_ctrl = 0; b_in_data = 0; b_out_ready = 0;
    ma = '0; mb = '0; sa = 0; sb = 0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    drive(0, 8'h00, 1, 0);
    for (int i = 1; i <= 5; i++) drive(1, CW'(i), 1, 0);
    drive(0, 8'h00, 1, 0);

    drive(1, 8'h11, 0, 0);
    drive(1, 8'h22, 0, 0);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 0, 0);
    repeat (3) drive(0, 8'h00, 1, 0);

    drive(1, 8'h44, 0, 0);
    drive(1, 8'h55, 0, 0);
    drive(1, 8'h33, 0, 1);
    drive(0, 8'h00, 0, 0);
    drive(0, 8'h00, 1, 0);

    drive(1, 8'h66, 0, 0);
    drive(1, 8'h77, 0, 0);
    drive(1, 8'h77, 1, 0);
    repeat (3) drive(0, 8'h00, 1, 0);

    drive(1, 8'h5a, 0, 0);
    repeat (20) drive(0, 8'h00, 0, 0);
    chk("a_stall_saturated", a_stall, 4'hF);
    repeat (2) drive(0, 8'h00, 1, 0);

    reset = 1'b1;
    drive(0, 8'h00, 1, 0);
    reset = 1'b0;

    for (int n = 0; n < 400; n++) begin
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_in_ctrl = CW'($urandom);
      a_in_data = rnd_data();
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush = ($urandom_range(0, 19) == 0);
      b_in_valid = ($urandom_range(0, 3) != 0);
      b_in_ctrl = CW'($urandom);
      b_in_data = rnd_data();
      b_out_ready = ($urandom_range(0, 2) != 0);
      b_flush = ($urandom_range(0, 19) == 0);
      reset = ($urandom_range(0, 99) == 0);
      tick();
    end
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
